fc2_result_reader: RTL

- Reads back the 32-entry FC2 output RAM after the FC2 layer finishes writing it, using a 26-bit word per entry at addresses 0..31.
- Streams every entry to the host side over a valid/ready interface.
- Computes the argmax (classification result) on the fly.
- Sits between the FC2 output RAM read port and the PS/DMA-facing result stream. It is the read-side counterpart of the layer's wren/addr/data write port.

---
 rtl/fc2_result_reader_pkg.sv | 25 ++
 rtl/result_skid_fifo.sv | 70 +++++++
 rtl/fc2_result_reader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/fc2_result_reader_pkg.sv
// Constants shared with the FC2 layer and its output RAM, plus the reader FSM
// encoding and the layout of one buffered result beat.
package fc2_result_reader_pkg;

  localparam int OUTPUT_DIM        = 32;
  localparam int DATA_WIDTH        = 26;
  localparam int ADDR_WIDTH        = 5;
  localparam int RESULT_FIFO_DEPTH = 2;
  localparam int BEAT_WIDTH        = 1 + ADDR_WIDTH + DATA_WIDTH;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(OUTPUT_DIM - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_t;

  typedef struct packed {
    logic                  last;
    logic [ADDR_WIDTH-1:0] idx;
    logic [DATA_WIDTH-1:0] data;
  } result_beat_t;

endpackage

// File: rtl/result_skid_fifo.sv
// Small synchronous FIFO that holds returned RAM words until the stream consumer
// accepts them; push and pop may coincide even when full.
module result_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  always_comb begin
    pop_ok   = pop_i && (count_q != '0);
    push_ok  = push_i && ((count_q != CNT_FULL) || pop_ok);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/fc2_result_reader.sv
// Reads the FC2 output RAM back after the layer finishes, streams every entry to
// the host over valid/ready and tracks the argmax as the words return.
module fc2_result_reader
  import fc2_result_reader_pkg::*;
#(
  parameter int FIFO_DEPTH = RESULT_FIFO_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o,
  output logic [ADDR_WIDTH-1:0] class_idx_o,
  output logic [DATA_WIDTH-1:0] class_max_o
);

  localparam int CREDIT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CREDIT_W-1:0] CREDIT_MAX = CREDIT_W'(FIFO_DEPTH);

  reader_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_WIDTH-1:0] inflight_idx_q, inflight_idx_d;
  logic                  inflight_q, inflight_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [DATA_WIDTH-1:0] run_max_q, run_max_d;
  logic [ADDR_WIDTH-1:0] run_idx_q, run_idx_d;
  logic [DATA_WIDTH-1:0] class_max_q, class_max_d;
  logic [ADDR_WIDTH-1:0] class_idx_q, class_idx_d;
  logic                  done_q, done_d;

  logic                  start_ok, issue, pop, last_pop;
  logic                  fifo_empty, fifo_full;
  logic [CREDIT_W-1:0]   fifo_count;
  result_beat_t          push_beat, head_beat;
  logic                  unused_fifo_status;

  assign start_ok = (state_q == ST_IDLE) && start_i && !done_q;
  assign pop      = !fifo_empty && m_ready_i;
  assign last_pop = pop && head_beat.last;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_READ;
      ST_READ:  if (issue && (rd_cnt_q == LAST_ADDR)) state_d = ST_DRAIN;
      ST_DRAIN: if (last_pop) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // credit_q counts FIFO entries plus the read in flight, so a read is only
  // issued when its return is guaranteed a slot; a pop this cycle frees one.
  always_comb begin
    busy_o  = (state_q != ST_IDLE);
    rd_en_o = (state_q == ST_READ) && ((credit_q < CREDIT_MAX) || pop);
  end

  assign issue = rd_en_o;

  always_comb begin
    rd_cnt_d       = rd_cnt_q;
    rd_addr_d      = rd_addr_q;
    inflight_idx_d = inflight_idx_q;
    inflight_d     = issue;
    credit_d       = credit_q;
    run_max_d      = run_max_q;
    run_idx_d      = run_idx_q;
    class_max_d    = class_max_q;
    class_idx_d    = class_idx_q;
    done_d         = last_pop;

    if (state_q == ST_IDLE) rd_cnt_d = '0;
    else if (issue && (rd_cnt_q != LAST_ADDR)) rd_cnt_d = rd_cnt_q + 1'b1;

    if (issue) begin
      rd_addr_d      = rd_cnt_q;
      inflight_idx_d = rd_cnt_q;
    end

    case ({issue, pop})
      2'b10:   credit_d = credit_q + 1'b1;
      2'b01:   credit_d = credit_q - 1'b1;
      default: credit_d = credit_q;
    endcase

    // Strict compare keeps the lower index on ties.
    if (state_q == ST_IDLE) begin
      run_max_d = '0;
      run_idx_d = '0;
    end else if (inflight_q && (rd_data_i > run_max_q)) begin
      run_max_d = rd_data_i;
      run_idx_d = inflight_idx_q;
    end

    if (last_pop) begin
      class_max_d = run_max_q;
      class_idx_d = run_idx_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rd_cnt_q       <= '0;
      rd_addr_q      <= '0;
      inflight_idx_q <= '0;
      inflight_q     <= 1'b0;
      credit_q       <= '0;
      run_max_q      <= '0;
      run_idx_q      <= '0;
      class_max_q    <= '0;
      class_idx_q    <= '0;
      done_q         <= 1'b0;
    end else begin
      rd_cnt_q       <= rd_cnt_d;
      rd_addr_q      <= rd_addr_d;
      inflight_idx_q <= inflight_idx_d;
      inflight_q     <= inflight_d;
      credit_q       <= credit_d;
      run_max_q      <= run_max_d;
      run_idx_q      <= run_idx_d;
      class_max_q    <= class_max_d;
      class_idx_q    <= class_idx_d;
      done_q         <= done_d;
    end
  end

  always_comb begin
    push_beat.last = (inflight_idx_q == LAST_ADDR);
    push_beat.idx  = inflight_idx_q;
    push_beat.data = rd_data_i;
  end

  result_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BEAT_WIDTH),
    .CNT_W (CREDIT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .push_i      (inflight_q),
    .push_data_i (push_beat),
    .pop_i       (pop),
    .head_o      (head_beat),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  assign unused_fifo_status = ^{fifo_full, fifo_count, head_beat.idx};

  assign rd_addr_o   = issue ? rd_cnt_q : rd_addr_q;
  assign m_valid_o   = !fifo_empty;
  assign m_data_o    = head_beat.data;
  assign m_last_o    = head_beat.last;
  assign done_o      = done_q;
  assign class_idx_o = class_idx_q;
  assign class_max_o = class_max_q;

endmodule
